ffdiv_arbiter: RTL and testbench
================================

Name: ffdiv_arbiter

Overview:
- Round-robin scheduler that shares one 32-bit floating-point divider (the iterative Goldschmidt FSM divider) among NUM_REQ requesters.
- Accepts operand pairs on per-requester valid/ready handshakes and holds the winning operands stable at the operand decoder input.
- Pulses the decoder-valid start, keeps the divider enable high until the divider reports ready, then returns the packed result and flags to the owning requester.
- Sits between the core's issue logic and the decoder + divider pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), requester index width
TIMEOUT_CYC, 64, WAIT-state watchdog limit in cycles (used only with FFDIV_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_a  in  32*NUM_REQ  dividend, IEEE-754 single; slice i belongs to requester i
req_b  in  32*NUM_REQ  divisor, IEEE-754 single
req_ready  out  NUM_REQ  one-hot grant / accept
rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
rsp_data  out  32  {sign, exp, frac} result
rsp_flags  out  5  {nanf, ovf, inf, uf, zf}
rsp_err  out  1  timeout abort (0 when macro absent)
rsp_id  out  ID_W  requester index of rsp_valid
busy  out  1  divider owned
div_en  out  1  divider enable
div_start  out  1  decoder valid (dec_valid)
div_op_a  out  32  registered operand to decoder
div_op_b  out  32  registered operand to decoder
div_soft_rst_n  out  1  divider/decoder reset qualifier, ANDed with rst_n at top level
div_ready  in  1  divider ready
div_result  in  32  divider {sign, exp, frac}
div_flags  in  5  divider {nanf, ovf, inf, uf, zf}

Behaviour:
- Reset, asynchronous and active-low:
  - State returns to IDLE.
  - All outputs are 0 except div_soft_rst_n = 1.
  - Round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
  - A reset mid-operation abandons the transaction; no rsp_valid is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is computed combinationally: the first asserted req_valid searching from pointer+1 upward, wrapping at NUM_REQ.
  - req_ready is the one-hot winner, asserted only in IDLE.
  - On handshake (req_valid[i] & req_ready[i]) at the rising edge:
    - latch req_a[i] and req_b[i] into div_op_a/div_op_b;
    - latch i into the owner register;
    - set pointer to i;
    - go to ISSUE.
- ISSUE (exactly 1 cycle): div_en=1, div_start=1; go to WAIT.
- WAIT:
  - div_en=1, div_start=0.
  - On the edge sampling div_ready=1: capture div_result/div_flags into the rsp registers; go to RESP.
  - div_op_a/div_op_b stay unchanged from grant until leaving RESP.
- RESP (1 cycle):
  - div_en=0.
  - rsp_valid[owner]=1 and rsp_id=owner; rsp_data/rsp_flags hold the captured values.
  - Go to IDLE.
  - rsp_data/flags/id hold until the next RESP.
- busy = (state != IDLE).
- Latency: handshake edge to rsp_valid is 3 + divider cycles (SETUP + ITERATE count + ROUND + ENCODE).
- Throughput: one division per latency + 1 cycles.
- Boundary rules:
  - Requests arriving outside IDLE wait; req_ready stays 0.
  - Deasserting req_valid after acceptance has no effect.
  - A sole requester is re-granted back-to-back.
  - All NUM_REQ requesters asserted continuously are served strictly in rotation 0,1,2,3,0,…
  - div_ready high in ISSUE is ignored, because the divider cannot be ready before SETUP.
  - Special operands (NaN, inf, zero, denormal) need no special handling; the divider's result and flags are passed through unchanged.

Optional Feature:
FFDIV_ARB_TIMEOUT_EN:
- Defined:
  - A WAIT-cycle counter increments each WAIT cycle and clears on entering WAIT.
  - When it reaches TIMEOUT_CYC without div_ready, the controller enters RESP with rsp_data=0x7FC00000, rsp_flags=5'b10000, rsp_err=1.
  - div_soft_rst_n is driven 0 for that RESP cycle, returning the divider to IDLE.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - rsp_err tied 0, div_soft_rst_n tied 1.

Test Plan:
- Requester 0: a=0x40C00000 (6.0), b=0x40000000 (2.0) → rsp_valid[0] one cycle, rsp_data=0x40400000, rsp_flags=0; div_start high exactly 1 cycle; div_en high from ISSUE through WAIT.
- All 4 requesters valid from reset with distinct operands → grant order 0,1,2,3,0; rsp_id matches; req_ready never multi-hot; operands stable while busy.
- Requester 2: 1.0/0.0 (0x3F800000/0x00000000) → rsp_data=0x7F800000, flags inf=1; requester 1 with a=0x7FC00001 → nanf=1, NaN payload propagated.
- Assert rst_n=0 mid-WAIT → all outputs 0 immediately, no rsp_valid; a new request after release is served from requester 0.
- With FFDIV_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, div_ready forced 0 → rsp_err=1, rsp_data=0x7FC00000, div_soft_rst_n low one cycle; the next request completes normally.

Source files
------------

// File: rtl/ffdiv_arbiter.sv
// Round-robin front end that shares one iterative 32-bit FP divider among NUM_REQ requesters.
// Define FFDIV_ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts a hung division.
module ffdiv_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [4:0]            rsp_flags,
    output logic                  rsp_err,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic                  div_en,
    output logic                  div_start,
    output logic [31:0]           div_op_a,
    output logic [31:0]           div_op_b,
    output logic                  div_soft_rst_n,
    input  logic                  div_ready,
    input  logic [31:0]           div_result,
    input  logic [4:0]            div_flags
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] owner_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic [31:0]     op_a_reg;
    logic [31:0]     op_b_reg;
    logic [31:0]     rsp_data_reg;
    logic [4:0]      rsp_flags_reg;
    logic            timeout_hit;

    logic [31:0]        a_slice [NUM_REQ];
    logic [31:0]        b_slice [NUM_REQ];
    logic [ID_W-1:0]    cand_id [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               in_idle;
    logic               wait_done;

    assign in_idle   = (state_reg == ST_IDLE);
    assign wait_done = (state_reg == ST_WAIT) && (div_ready || timeout_hit);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[32*gi +: 32];
            assign b_slice[gi] = req_b[32*gi +: 32];
        end

        // Candidate gi is the requester (gi+1) places after the last winner, wrapping at NUM_REQ.
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum          = {1'b0, ptr_reg} + (ID_W + 1)'(gi + 1);
            assign cand_id[gi]  = ID_W'((sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum);
            assign cand_hit[gi] = req_valid[cand_id[gi]];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_found = 1'b1;
                grant_id    = cand_id[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            // rst_n gating keeps req_ready low while reset is held, even with requests pending.
            assign req_ready[gi] = rst_n && in_idle && grant_found && (grant_id == ID_W'(gi));
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_found) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (wait_done) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= ID_W'(NUM_REQ - 1);
            owner_reg     <= '0;
            rsp_id_reg    <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            rsp_data_reg  <= '0;
            rsp_flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (in_idle && grant_found) begin
                op_a_reg  <= a_slice[grant_id];
                op_b_reg  <= b_slice[grant_id];
                owner_reg <= grant_id;
                ptr_reg   <= grant_id;
            end
            // div_ready is only honoured in WAIT; a stale ready during ISSUE is ignored.
            if (state_reg == ST_WAIT) begin
                if (div_ready) begin
                    rsp_data_reg  <= div_result;
                    rsp_flags_reg <= div_flags;
                    rsp_id_reg    <= owner_reg;
                end else if (timeout_hit) begin
                    rsp_data_reg  <= 32'h7FC0_0000;
                    rsp_flags_reg <= 5'b10000;
                    rsp_id_reg    <= owner_reg;
                end
            end
        end
    end

`ifdef FFDIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             rsp_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_ISSUE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th WAIT cycle; a real div_ready on that cycle still wins.
    assign timeout_hit = (state_reg == ST_WAIT) && !div_ready
                         && (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else if (wait_done) begin
            rsp_err_reg <= !div_ready;
        end
    end

    assign rsp_err        = rsp_err_reg;
    assign div_soft_rst_n = !((state_reg == ST_RESP) && rsp_err_reg);
`else
    assign timeout_hit    = 1'b0;
    assign rsp_err        = 1'b0;
    assign div_soft_rst_n = 1'b1;
`endif

    assign busy      = !in_idle;
    assign div_en    = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign div_start = (state_reg == ST_ISSUE);
    assign div_op_a  = op_a_reg;
    assign div_op_b  = op_b_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_flags = rsp_flags_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_ffdiv_arbiter.sv
// Randomized bench for ffdiv_arbiter: a transaction-level arbitration model plus a stand-in divider.
module tb_ffdiv_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef FFDIV_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic [4:0]      rsp_flags;
    logic            rsp_err;
    logic [IDW-1:0]  rsp_id;
    logic            busy;
    logic            div_en;
    logic            div_start;
    logic [31:0]     div_op_a;
    logic [31:0]     div_op_b;
    logic            div_soft_rst_n;
    logic            div_ready;
    logic [31:0]     div_result;
    logic [4:0]      div_flags;

    always #5 clk = ~clk;

    ffdiv_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy),
        .div_en(div_en), .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
        .div_soft_rst_n(div_soft_rst_n), .div_ready(div_ready),
        .div_result(div_result), .div_flags(div_flags)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behaviour of the stand-in divider: returns {flags, result}.
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF && a[22:0] != 0) return {5'b10000, a | 32'h0040_0000};
        if (b[30:0] == 0) return {5'b00100, a[31] ^ b[31], 31'h7F80_0000};
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {5'b00000, 32'h4040_0000};
        return {a[4:0] ^ b[9:5], a ^ {b[15:0], b[31:16]}};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7F80_0000;
            2:       return 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
            3:       return $urandom & 32'h807F_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic int winner(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Stand-in divider: ready idles high, drops on start, returns after m_lat cycles unless stalled.
    logic        d_stall = 1'b0;
    int          m_lat = 1;
    int          d_cnt;
    logic [31:0] d_a;
    logic [31:0] d_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ready  <= 1'b1;
            d_cnt      <= 0;
            div_result <= '0;
            div_flags  <= '0;
        end else if (!div_soft_rst_n) begin
            div_ready <= 1'b1;
            d_cnt     <= 0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            d_cnt     <= m_lat;
            d_a       <= div_op_a;
            d_b       <= div_op_b;
        end else if (d_cnt != 0 && !d_stall) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) begin
                div_ready               <= 1'b1;
                {div_flags, div_result} <= ref_div(d_a, d_b);
            end
        end
    end

    // Transaction-level reference: grant rule, response timing and held response values.
    bit          m_busy = 0;
    bit          m_to = 0;
    int          m_owner = 0;
    int          m_ptr = N - 1;
    int          m_hs_cyc = 0;
    int          m_rsp_at = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    logic [31:0] m_op_a, m_op_b, m_data;
    logic [4:0]  m_flags;
    logic [31:0] last_data = '0;
    logic [4:0]  last_flags = '0;
    int          last_id = 0;
    bit          last_err = 0;
    int          grant_log[$];

    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        int           w;
        bit           rsp_now;
        if (!rst_n) begin
            m_busy = 0; m_ptr = N - 1; cyc = 0;
            last_data = '0; last_flags = '0; last_id = 0; last_err = 0;
        end else begin
            cyc++;
            exp_rdy = '0;
            w = -1;
            if (!m_busy) begin
                w = winner(m_ptr, req_valid);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            rsp_now = m_busy && (cyc == m_rsp_at);
            exp_rv = '0;
            if (rsp_now) begin
                exp_rv[m_owner] = 1'b1;
                last_data = m_data; last_flags = m_flags; last_id = m_owner; last_err = m_to;
            end
            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, exp_rv);
            check("busy", busy, m_busy);
            check("div_start", div_start, m_busy && (cyc == m_hs_cyc + 1));
            check("div_en", div_en, m_busy && !rsp_now);
            check("soft_rst_n", div_soft_rst_n, !(rsp_now && m_to));
            check("rsp_data", rsp_data, last_data);
            check("rsp_flags", rsp_flags, last_flags);
            check("rsp_id", rsp_id, last_id);
            check("rsp_err", rsp_err, last_err);
            if (m_busy) begin
                check("op_a_stable", div_op_a, m_op_a);
                check("op_b_stable", div_op_b, m_op_b);
            end
            if (rsp_now) begin
                m_busy = 0;
                n_rsp++;
                $display("rsp id=%0d data=%h flags=%b err=%0d", m_owner, m_data, m_flags, m_to);
            end else if (w >= 0) begin
                m_busy   = 1;
                m_owner  = w;
                m_ptr    = w;
                m_hs_cyc = cyc;
                m_lat    = $urandom_range(1, 6);
                m_to     = d_stall;
                m_op_a   = req_a[32*w +: 32];
                m_op_b   = req_b[32*w +: 32];
                m_rsp_at = cyc + 2 + (m_to ? TO : m_lat + 1);
                {m_flags, m_data} = m_to ? {5'b10000, 32'h7FC0_0000} : ref_div(m_op_a, m_op_b);
                grant_log.push_back(w);
            end
        end
    end

    task automatic wait_rsp(input int target);
        int t = 0;
        while (n_rsp < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("rsp_wait", n_rsp, target);
    endtask

    task automatic wait_grants(input int target);
        int t = 0;
        while (grant_log.size() < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("grant_wait", grant_log.size(), target);
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input bit wait_done);
        int t = 0;
        int base;
        @(posedge clk); #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id] = 1'b1;
        @(negedge clk);
        while (!req_ready[id] && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", req_ready[id], 1'b1);
        base = n_rsp;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (wait_done) wait_rsp(base + 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, busy, div_en, div_start, rsp_err, rsp_id, rsp_flags}, '0);
        check({tag, "_data"}, rsp_data, '0);
        check({tag, "_ops"}, {div_op_a[4:0], div_op_a | div_op_b}, '0);
        check({tag, "_soft"}, div_soft_rst_n, 1'b1);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int start;
        int n_before;
        int t;
        rst_n = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;

        // Directed divisions with pass-through results.
        issue(0, 32'h40C0_0000, 32'h4000_0000, 1'b1);
        check("six_by_two_data", rsp_data, 32'h4040_0000);
        check("six_by_two_flags", rsp_flags, 5'b00000);
        check("six_by_two_id", rsp_id, 0);
        issue(2, 32'h3F80_0000, 32'h0000_0000, 1'b1);
        check("div_zero_data", rsp_data, 32'h7F80_0000);
        check("div_zero_flags", rsp_flags, 5'b00100);
        check("div_zero_id", rsp_id, 2);
        issue(1, 32'h7FC0_0001, 32'h3F80_0000, 1'b1);
        check("nan_data", rsp_data, 32'h7FC0_0001);
        check("nan_flags", rsp_flags, 5'b10000);

        // All requesters held valid from reset: strict rotation, operands churn while busy.
        do_reset();
        start = grant_log.size();
        t = 0;
        @(posedge clk); #1 req_valid = '1;
        while (grant_log.size() < start + 8 && t < 400) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = rand_op();
                req_b[32*i +: 32] = rand_op();
            end
            @(posedge clk); #1;
            t++;
        end
        check("rotation_grants", grant_log.size(), start + 8);
        for (int k = 0; k < 8 && start + k < grant_log.size(); k++) begin
            check("rotation_order", grant_log[start + k], k % N);
        end
        req_valid = '0;

        // Sole requester is re-granted back-to-back.
        @(posedge clk); #1 req_valid = 4'b0010;
        start = grant_log.size();
        wait_grants(start + 3);
        for (int k = 0; k < 3 && start + k < grant_log.size(); k++) begin
            check("sole_grant", grant_log[start + k], 1);
        end
        @(posedge clk); #1 req_valid = '0;

        // Reset in the middle of WAIT abandons the transaction.
        issue(2, 32'h4120_0000, 32'h4040_0000, 1'b0);
        t = 0;
        while (!(busy && div_en && !div_start) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reached_wait", {busy, div_en, div_start}, 3'b110);
        n_before = n_rsp;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_wait_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_rsp_after_reset", n_rsp, n_before);
        @(posedge clk); #1 req_valid = 4'b1001;
        start = grant_log.size();
        wait_grants(start + 1);
        if (grant_log.size() > start) check("post_reset_winner", grant_log[start], 0);
        @(posedge clk); #1 req_valid = '0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_a[32*i +: 32] = rand_op();
                req_b[32*i +: 32] = rand_op();
            end
        end
        @(posedge clk); #1 req_valid = '0;

`ifdef FFDIV_ARB_TIMEOUT_EN
        // Hung divider: watchdog aborts with a quiet NaN, then normal service resumes.
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1 d_stall = 1'b1;
        issue(3, 32'h4000_0000, 32'h3F80_0000, 1'b1);
        check("timeout_err", rsp_err, 1'b1);
        check("timeout_data", rsp_data, 32'h7FC0_0000);
        check("timeout_flags", rsp_flags, 5'b10000);
        @(posedge clk); #1 d_stall = 1'b0;
        issue(3, 32'h40C0_0000, 32'h4000_0000, 1'b1);
        check("after_timeout_data", rsp_data, 32'h4040_0000);
        check("after_timeout_err", rsp_err, 1'b0);
`endif

        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drained", busy, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
